usc_rv_iss_opq: RTL and testbench



---
 rtl/usc_rv_iss_opq_if.sv | 26 ++
 rtl/usc_rv_iss_opq.sv | 110 +++++++++++
 tb/tb_usc_rv_iss_opq.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/usc_rv_iss_opq_if.sv
// Decode/issue-side bundle of the usc_rv_iss_opq in-order op queue.
// Enqueue groups are accepted on any edge where enq_rdy=1; ops offered while enq_rdy=0 are dropped
// and decode must hold them. deq_take counts the window lanes consumed on an edge, taken from lane 0 up.
interface usc_rv_iss_opq_if #(
   parameter int DEPTH = 8,
   parameter int OP_W  = 64,
   parameter int LANES = 2
);
   logic [LANES-1:0]               enq_vld;
   logic [LANES*OP_W-1:0]          enq_op;
   logic                           enq_rdy;
   logic [LANES-1:0]               deq_vld;
   logic [LANES*OP_W-1:0]          deq_op;
   logic [$clog2(LANES+1)-1:0]     deq_take;
   logic [$clog2(DEPTH+1)-1:0]     count;

   modport master (
      output enq_vld, enq_op, deq_take,
      input  enq_rdy, deq_vld, deq_op, count
   );

   modport slave (
      input  enq_vld, enq_op, deq_take,
      output enq_rdy, deq_vld, deq_op, count
   );
endinterface

// File: rtl/usc_rv_iss_opq.sv
// In-order issue op queue: LANES-wide enqueue, LANES-wide issue window, variable take from the head.
// Optional same-cycle enqueue->issue bypass when the queue is nearly empty: define USC_RV_OPQ_BYPASS_EN.
module usc_rv_iss_opq #(
   parameter int DEPTH = 8,
   parameter int OP_W  = 64,
   parameter int LANES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   usc_rv_iss_opq_if.slave  opq
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [OP_W-1:0]        r_mem [DEPTH];
   logic [PW-1:0]          r_head;
   logic [PW-1:0]          r_tail;
   logic [CW-1:0]          r_count;

   logic                   w_kill;
   logic [CW:0]            w_free;
   logic                   w_rdy;
   logic [CW-1:0]          w_n_vld;
   logic [CW-1:0]          w_n_enq;
   logic [CW-1:0]          w_n_win;
   logic [CW-1:0]          w_req;
   logic [CW-1:0]          w_n_take;
   logic [CW-1:0]          w_n_skip;
   logic [LANES-1:0]       w_deq_vld;
   logic [LANES*OP_W-1:0]  w_deq_op;

   assign w_kill = reset | flush;

   // Ready looks only at registered occupancy so it stays off the take path.
   assign w_free = (CW+1)'(DEPTH) - {1'b0, r_count};
   assign w_rdy  = ~w_kill & (w_free >= (CW+1)'(LANES));

   always_comb begin
      w_n_vld = '0;
      for (int i = 0; i < LANES; i++) begin
         w_n_vld = w_n_vld + CW'(opq.enq_vld[i]);
      end
   end

   assign w_n_enq = w_rdy ? w_n_vld : '0;

   always_comb begin
      w_deq_vld = '0;
      w_deq_op  = '0;
      for (int i = 0; i < LANES; i++) begin
         if (CW'(i) < r_count) begin
            w_deq_vld[i]               = 1'b1;
            w_deq_op[i*OP_W +: OP_W]   = r_mem[r_head + PW'(i)];
         end
`ifdef USC_RV_OPQ_BYPASS_EN
         else begin
            // Lane i shows accepted enqueue lane j where j = i - count.
            for (int j = 0; j < LANES; j++) begin
               if ((CW'(j) < w_n_enq) && ((r_count + CW'(j)) == CW'(i))) begin
                  w_deq_vld[i]             = 1'b1;
                  w_deq_op[i*OP_W +: OP_W] = opq.enq_op[j*OP_W +: OP_W];
               end
            end
         end
`endif
      end
      if (w_kill) begin
         w_deq_vld = '0;
      end
   end

   always_comb begin
      w_n_win = '0;
      for (int i = 0; i < LANES; i++) begin
         w_n_win = w_n_win + CW'(w_deq_vld[i]);
      end
   end

   assign w_req    = CW'(opq.deq_take);
   assign w_n_take = (w_req < w_n_win) ? w_req : w_n_win;
   // Ops consumed straight out of the enqueue group never land in storage.
   assign w_n_skip = (w_n_take > r_count) ? (w_n_take - r_count) : '0;

   always_ff @(posedge clk) begin
      if (w_kill) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         r_head  <= r_head + PW'(w_n_take);
         r_tail  <= r_tail + PW'(w_n_enq);
         r_count <= r_count + w_n_enq - w_n_take;
      end
   end

   // Skipped lanes keep their slot offset so surviving ops stay at tail+j, matching head'.
   always_ff @(posedge clk) begin
      for (int j = 0; j < LANES; j++) begin
         if (!w_kill && (CW'(j) < w_n_enq) && (CW'(j) >= w_n_skip)) begin
            r_mem[r_tail + PW'(j)] <= opq.enq_op[j*OP_W +: OP_W];
         end
      end
   end

   assign opq.enq_rdy = w_rdy;
   assign opq.deq_vld = w_deq_vld;
   assign opq.deq_op  = w_deq_op;
   assign opq.count   = r_count;
endmodule

// File: tb/tb_usc_rv_iss_opq.sv
// Bench for usc_rv_iss_opq: queue-based reference model with a per-cycle compare, directed scenarios and random traffic.
module tb_usc_rv_iss_opq;
   localparam int DEPTH = 8;
   localparam int OP_W  = 64;
   localparam int LANES = 2;
   localparam int TW    = $clog2(LANES+1);
`ifdef USC_RV_OPQ_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   logic flush;

   usc_rv_iss_opq_if #(.DEPTH(DEPTH), .OP_W(OP_W), .LANES(LANES)) bus ();

   usc_rv_iss_opq #(.DEPTH(DEPTH), .OP_W(OP_W), .LANES(LANES)) dut (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .opq   (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;
   bit model_ok = 1'b0;
   logic [OP_W-1:0] exp_q[$];
   logic [OP_W-1:0] vis_q[$];

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [OP_W-1:0] mk(int t);
      return {32'hC0DE_0000 + 32'(t), 32'(t)};
   endfunction

   function automatic bit model_rdy();
      return !reset && !flush && ((DEPTH - exp_q.size()) >= LANES);
   endfunction

   // What the issue window must show: stored ops, then (with bypass) the accepted group.
   task automatic build_vis();
      vis_q = exp_q;
      if (BYP && model_rdy()) begin
         for (int j = 0; j < $countones(bus.enq_vld); j++) begin
            vis_q.push_back(bus.enq_op[j*OP_W +: OP_W]);
         end
      end
   endtask

   always @(negedge clk) begin
      if (model_ok) begin
         build_vis();
         chk("enq_rdy", 64'(bus.enq_rdy), 64'(model_rdy()));
         chk("count", 64'(bus.count), 64'(exp_q.size()));
         for (int i = 0; i < LANES; i++) begin
            bit ev;
            ev = !(reset || flush) && (i < vis_q.size());
            chk("deq_vld", 64'(bus.deq_vld[i]), 64'(ev));
            if (ev) chk("deq_op", bus.deq_op[i*OP_W +: OP_W], vis_q[i]);
         end
      end
   end

   always @(posedge clk) begin
      if (reset || flush) begin
         exp_q.delete();
         if (reset) model_ok = 1'b1;
      end else begin
         int na, nw, nt;
         build_vis();
         na = model_rdy() ? $countones(bus.enq_vld) : 0;
         nw = (vis_q.size() < LANES) ? vis_q.size() : LANES;
         nt = (int'(bus.deq_take) < nw) ? int'(bus.deq_take) : nw;
         for (int j = 0; j < na; j++) exp_q.push_back(bus.enq_op[j*OP_W +: OP_W]);
         repeat (nt) void'(exp_q.pop_front());
      end
   end

   task automatic drive(bit r, bit f, int nv, int take);
      reset        = r;
      flush        = f;
      bus.enq_vld  = LANES'((1 << nv) - 1);
      bus.deq_take = TW'(take);
   endtask

   task automatic set_ops(int base);
      for (int j = 0; j < LANES; j++) bus.enq_op[j*OP_W +: OP_W] = mk(base + j);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   int t_next;
   int iss_next;

   initial begin
      bus.enq_op = '0;
      drive(1, 0, 0, 0);
      step();
      step();
      chk("rst_deq_vld", 64'(bus.deq_vld), 64'd0);
      chk("rst_enq_rdy", 64'(bus.enq_rdy), 64'd0);
      drive(0, 0, 0, 0);
      #1;
      chk("post_rst_count", 64'(bus.count), 64'd0);
      chk("post_rst_rdy", 64'(bus.enq_rdy), 64'd1);

      // A,B with no take
      set_ops(100);
      drive(0, 0, 2, 0);
      #1;
`ifdef USC_RV_OPQ_BYPASS_EN
      chk("ab_bypass_vld", 64'(bus.deq_vld), 64'd3);
`endif
      step();
      drive(0, 0, 0, 0);
      #1;
      chk("ab_count", 64'(bus.count), 64'd2);
      chk("ab_vld", 64'(bus.deq_vld), 64'd3);
      chk("ab_lane0", bus.deq_op[0 +: OP_W], mk(100));
      chk("ab_lane1", bus.deq_op[OP_W +: OP_W], mk(101));

      // fill to full, fifth group dropped
      drive(0, 1, 0, 0);
      step();
      drive(0, 0, 0, 0);
      #1;
      chk("flush_count", 64'(bus.count), 64'd0);
      for (int k = 0; k < 4; k++) begin
         set_ops(200 + 2*k);
         drive(0, 0, 2, 0);
         #1;
         chk("fill_rdy", 64'(bus.enq_rdy), 64'd1);
         step();
         chk("fill_count", 64'(bus.count), 64'(2*(k+1)));
      end
      set_ops(300);
      #1;
      chk("full_rdy", 64'(bus.enq_rdy), 64'd0);
      step();
      drive(0, 0, 0, 0);
      #1;
      chk("full_count", 64'(bus.count), 64'd8);
      chk("full_lane0", bus.deq_op[0 +: OP_W], mk(200));

      // over-take
      drive(0, 1, 0, 0);
      step();
      set_ops(320);
      drive(0, 0, 1, 0);
      step();
      drive(0, 0, 0, 2);
      #1;
      chk("ot_count_before", 64'(bus.count), 64'd1);
      step();
      drive(0, 0, 0, 0);
      #1;
      chk("ot_count", 64'(bus.count), 64'd0);
      chk("ot_vld", 64'(bus.deq_vld), 64'd0);

      // partial take on an empty queue
      set_ops(400);
      drive(0, 0, 2, 1);
      #1;
`ifdef USC_RV_OPQ_BYPASS_EN
      chk("byp_vld", 64'(bus.deq_vld), 64'd3);
      chk("byp_lane0", bus.deq_op[0 +: OP_W], mk(400));
`endif
      step();
      drive(0, 0, 0, 0);
      #1;
`ifdef USC_RV_OPQ_BYPASS_EN
      chk("byp_count", 64'(bus.count), 64'd1);
      chk("byp_next_lane0", bus.deq_op[0 +: OP_W], mk(401));
`else
      chk("nobyp_count", 64'(bus.count), 64'd2);
      chk("nobyp_lane0", bus.deq_op[0 +: OP_W], mk(400));
`endif

      // flush at count 5 with a live enqueue group
      drive(0, 1, 0, 0);
      step();
      for (int k = 0; k < 3; k++) begin
         set_ops(500 + 2*k);
         drive(0, 0, (k == 2) ? 1 : 2, 0);
         step();
      end
      chk("pre_flush_count", 64'(bus.count), 64'd5);
      set_ops(600);
      drive(0, 1, 2, 0);
      #1;
      chk("flush_cyc_vld", 64'(bus.deq_vld), 64'd0);
      step();
      drive(0, 0, 0, 0);
      #1;
      chk("post_flush_count", 64'(bus.count), 64'd0);
      chk("post_flush_vld", 64'(bus.deq_vld), 64'd0);
      chk("post_flush_rdy", 64'(bus.enq_rdy), 64'd1);
      step();
      chk("post_flush_count2", 64'(bus.count), 64'd0);

      // steady enq 2 / take 2 at count 6 across the pointer wrap
      t_next   = 700;
      iss_next = 700;
      for (int k = 0; k < 3; k++) begin
         set_ops(t_next);
         drive(0, 0, 2, 0);
         step();
         t_next += 2;
      end
      for (int k = 0; k < 10; k++) begin
         set_ops(t_next);
         drive(0, 0, 2, 2);
         #1;
         chk("wrap_lane0", bus.deq_op[0 +: OP_W], mk(iss_next));
         chk("wrap_lane1", bus.deq_op[OP_W +: OP_W], mk(iss_next + 1));
         step();
         t_next   += 2;
         iss_next += 2;
         chk("wrap_count", 64'(bus.count), 64'd6);
      end

      // random traffic
      for (int c = 0; c < 3000; c++) begin
         for (int j = 0; j < LANES; j++) bus.enq_op[j*OP_W +: OP_W] = {$urandom, $urandom};
         drive(($urandom_range(0, 299) == 0), ($urandom_range(0, 39) == 0),
               $urandom_range(0, LANES), $urandom_range(0, (1 << TW) - 1));
         step();
      end

      drive(0, 0, 0, 0);
      step();
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
